// File: rtl/fsm_seq_det_param.sv
// Serial pattern detector: KMP-style prefix FSM with Mealy and Moore match outputs
// and a saturating hit counter. The next-state table is built at elaboration.
module fsm_seq_det_param #(
  parameter int          PAT_W   = 4,
  parameter logic [15:0] PATTERN = 16'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       din,
  output logic                       match_mealy,
  output logic                       match_moore,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [$clog2(PAT_W+1)-1:0] progress
);

  localparam int SW    = $clog2(PAT_W + 1);
  localparam int TBL_N = 2 ** (SW + 1);

  // state index k = number of pattern bits matched; PAT_W is the MATCH state
  typedef logic [SW-1:0] state_t;
  localparam state_t S_IDLE  = '0;
  localparam state_t S_MATCH = SW'(PAT_W);

  // bit i of the pattern in arrival order (i = 0 is received first)
  function automatic bit pbit(input int i);
    return PATTERN[PAT_W-1-i];
  endfunction

  // longest proper border of the full pattern
  function automatic int fail_len();
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < 16; l++) begin
      if (l < PAT_W) begin
        ok = 1'b1;
        for (int j = 0; j < 16; j++) begin
          if (j < l) begin
            if (pbit(j) != pbit(PAT_W - l + j)) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // longest pattern prefix that is a suffix of (first base pattern bits, d)
  function automatic int next_len(input int base, input bit d);
    int  best;
    int  n;
    int  k;
    bit  ok;
    bit  s;
    best = 0;
    n    = base + 1;
    for (int l = 1; l <= 16; l++) begin
      if (l <= n && l <= PAT_W) begin
        ok = 1'b1;
        for (int j = 0; j < 16; j++) begin
          if (j < l) begin
            k = n - l + j;
            s = (k < base) ? pbit(k) : d;
            if (pbit(j) != s) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  state_t     r_state;
  logic       r_moore;
  logic [CNT_W-1:0] r_hit_cnt;

  state_t     w_tbl [TBL_N];
  logic [SW:0] w_sel;
  state_t     w_next;
  state_t     w_state_nxt;
  logic       w_hit;

  // rows past MATCH are unreachable and tie to zero
  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    localparam int ST   = g / 2;
    localparam int BASE = (ST >= PAT_W) ? (OVERLAP ? fail_len() : 0) : ST;
    localparam int NX   = (ST > PAT_W) ? 0 : next_len(BASE, (g % 2) != 0);
    assign w_tbl[g] = SW'(NX);
  end

  always_comb begin
    w_sel       = {r_state, din};
    w_next      = w_tbl[w_sel];
    w_hit       = en && !reset && !clr && (w_next == S_MATCH);
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else if (en) begin
      w_state_nxt = w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state   <= S_IDLE;
      r_moore   <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (en) r_moore <= (w_next == S_MATCH);
      if (w_hit && (r_hit_cnt != {CNT_W{1'b1}})) r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign match_mealy = w_hit;
  assign match_moore = r_moore;
  assign hit_cnt     = r_hit_cnt;
  assign progress    = r_state;

endmodule
